// File: rtl/up_byte_assembler.sv
// Assembles uP byte streams into register-bank write/read transactions and
// serialises read data back to the uP one byte at a time, LSB first.
module up_byte_assembler #(
    parameter int unsigned DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    RW,
    input  logic [7:0]              in_byte,
    input  logic                    in_valid,
    input  logic [8*DATA_BYTES-1:0] reg_rdata,
    input  logic                    out_ack,
    output logic [7:0]              reg_address,
    output logic [8*DATA_BYTES-1:0] reg_wdata,
    output logic                    reg_write_strobe,
    output logic                    reg_read_strobe,
    output logic [7:0]              out_byte,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    frame_error
);

    localparam int unsigned REG_W = 8 * DATA_BYTES;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_ADDR = 3'd1;
    localparam logic [2:0] S_GET_DATA = 3'd2;
    localparam logic [2:0] S_DO_WRITE = 3'd3;
    localparam logic [2:0] S_DO_READ  = 3'd4;
    localparam logic [2:0] S_CAPTURE  = 3'd5;
    localparam logic [2:0] S_SEND     = 3'd6;

    localparam logic [2:0] LAST_BYTE = 3'(DATA_BYTES - 1);

    logic [2:0]       state_q, state_d;
    logic             rw_q, rw_d;
    logic [7:0]       addr_q, addr_d;
    logic [REG_W-1:0] wdata_q, wdata_d;
    logic [REG_W-1:0] shift_q, shift_d;
    logic [2:0]       byte_count_q, byte_count_d;
    logic             frame_error_q, frame_error_d;
    logic             abort;

    assign abort = start && (state_q != S_IDLE);

    always_comb begin
        state_d       = state_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        shift_d       = shift_q;
        byte_count_d  = byte_count_q;
        frame_error_d = 1'b0;

        if (abort) begin
            frame_error_d = 1'b1;
            rw_d          = RW;
            state_d       = S_GET_ADDR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rw_d    = RW;
                        state_d = S_GET_ADDR;
                    end
                end
                S_GET_ADDR: begin
                    if (in_valid) begin
                        addr_d = in_byte;
                        if (rw_q) begin
                            state_d = S_DO_READ;
                        end else begin
                            byte_count_d = '0;
                            state_d      = S_GET_DATA;
                        end
                    end
                end
                S_GET_DATA: begin
                    if (in_valid) begin
                        wdata_d[8*int'(byte_count_q) +: 8] = in_byte;
                        // saturate so an 8-byte configuration cannot wrap to lane 0
                        byte_count_d = (byte_count_q == 3'd7) ? byte_count_q
                                                              : byte_count_q + 3'd1;
                        if (byte_count_q == LAST_BYTE) begin
                            state_d = S_DO_WRITE;
                        end
                    end
                end
                S_DO_WRITE: state_d = S_IDLE;
                S_DO_READ:  state_d = S_CAPTURE;
                S_CAPTURE: begin
                    shift_d      = reg_rdata;
                    byte_count_d = '0;
                    state_d      = S_SEND;
                end
                S_SEND: begin
                    if (out_ack) begin
                        shift_d      = shift_q >> 8;
                        byte_count_d = (byte_count_q == 3'd7) ? byte_count_q
                                                              : byte_count_q + 3'd1;
                        if (byte_count_q == LAST_BYTE) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            shift_q       <= '0;
            byte_count_q  <= '0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            shift_q       <= shift_d;
            byte_count_q  <= byte_count_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Strobes are masked when the cycle is being aborted or reset, so such a
    // frame never reaches the register bank.
    assign reg_write_strobe = (state_q == S_DO_WRITE) && !start && !reset;
    assign reg_read_strobe  = (state_q == S_DO_READ)  && !start && !reset;
    assign out_valid        = (state_q == S_SEND);
    assign busy             = (state_q != S_IDLE);
    assign frame_error      = frame_error_q;
    assign out_byte         = shift_q[7:0];
    assign reg_address      = addr_q;
    assign reg_wdata        = wdata_q;

endmodule

// File: tb/tb_up_byte_assembler.sv
// Randomised scoreboard bench for up_byte_assembler with a transaction-level
// model of the register bank and the uP byte protocol.
module tb_up_byte_assembler;

    localparam int unsigned NB = 4;

    logic        clk = 1'b0;
    logic        reset, start, RW, in_valid, out_ack;
    logic [7:0]  in_byte;
    logic [31:0] reg_rdata = '0;
    logic [7:0]  reg_address, out_byte;
    logic [31:0] reg_wdata;
    logic        reg_write_strobe, reg_read_strobe, out_valid, busy, frame_error;

    always #5 clk = ~clk;

    up_byte_assembler #(.DATA_BYTES(NB)) dut (
        .clk(clk), .reset(reset), .start(start), .RW(RW),
        .in_byte(in_byte), .in_valid(in_valid), .reg_rdata(reg_rdata),
        .out_ack(out_ack), .reg_address(reg_address), .reg_wdata(reg_wdata),
        .reg_write_strobe(reg_write_strobe), .reg_read_strobe(reg_read_strobe),
        .out_byte(out_byte), .out_valid(out_valid), .busy(busy),
        .frame_error(frame_error)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    wr_t         wq[$];
    logic [7:0]  rq[$];
    logic [7:0]  oq[$];
    logic [31:0] bank_q[$];
    int          fe_expect = 0;
    bit          mid_frame = 0;
    int          cyc = 0;
    int          rs_cyc = -100;
    bit          ov_prev = 0;
    bit          rd_pend = 0;
    logic [31:0] rd_val = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int unsigned maxn);
        int unsigned n;
        n = $urandom_range(0, maxn);
        repeat (n) begin
            in_byte = 8'($urandom);
            cycle();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        cycle();
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"},  reg_address, 0);
        chk({tag, "_wdata"}, reg_wdata, 0);
        chk({tag, "_obyte"}, out_byte, 0);
        chk({tag, "_oval"},  out_valid, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_ferr"},  frame_error, 0);
        chk({tag, "_wstb"},  reg_write_strobe, 0);
        chk({tag, "_rstb"},  reg_read_strobe, 0);
    endtask

    // Issue start; a frame still in flight makes this an abort.
    task automatic begin_frame(input logic rw, input logic with_byte);
        bit was_mid;
        was_mid = mid_frame;
        if (was_mid) fe_expect++;
        start    = 1'b1;
        RW       = rw;
        in_valid = with_byte;
        in_byte  = 8'($urandom);
        cycle();
        start    = 1'b0;
        in_valid = 1'b0;
        RW       = 1'($urandom);
        chk("fe_after_start", frame_error, {63'd0, was_mid});
        chk("start_busy", busy, 1);
        mid_frame = 1;
    endtask

    task automatic write_frame(input logic [7:0] addr, input logic [31:0] data,
                               input int unsigned nbytes, input logic with_byte);
        begin_frame(1'b0, with_byte);
        gap(2);
        send_byte(addr);
        for (int unsigned i = 0; i < nbytes; i++) begin
            gap(2);
            if (i == NB - 1) wq.push_back('{addr: addr, data: data});
            send_byte(data[8*i +: 8]);
        end
        if (nbytes == NB) begin
            chk("wr_strobe_latency", reg_write_strobe, 1);
            cycle();
            chk("wr_done_idle", busy, 0);
            mid_frame = 0;
        end
    endtask

    task automatic read_frame(input logic [7:0] addr, input logic [31:0] rdata,
                              input int unsigned n_ack);
        begin_frame(1'b1, 1'($urandom));
        gap(2);
        rq.push_back(addr);
        bank_q.push_back(rdata);
        send_byte(addr);
        chk("rd_strobe_latency", reg_read_strobe, 1);
        for (int k = 0; k < 10 && !out_valid; k++) begin
            out_ack = 1'($urandom);
            cycle();
            out_ack = 1'b0;
        end
        chk("rd_out_valid_seen", out_valid, 1);
        for (int unsigned i = 0; i < n_ack; i++) begin
            gap(2);
            oq.push_back(rdata[8*i +: 8]);
            out_ack = 1'b1;
            cycle();
            out_ack = 1'b0;
        end
        if (n_ack == NB) begin
            chk("rd_done_oval", out_valid, 0);
            chk("rd_done_busy", busy, 0);
            mid_frame = 0;
        end
    endtask

    task automatic reset_mid();
        reset    = 1'b1;
        start    = 1'b1;
        RW       = 1'($urandom);
        in_valid = 1'b1;
        in_byte  = 8'($urandom);
        out_ack  = 1'b1;
        cycle();
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        out_ack  = 1'b0;
        check_zero("midrst");
        mid_frame = 0;
    endtask

    // Register bank: data appears the cycle after the read strobe, random otherwise.
    always @(negedge clk) begin
        if (rd_pend) reg_rdata = rd_val;
        else reg_rdata = $urandom;
        rd_pend = 0;
        if (reg_read_strobe) begin
            chk("bank_data_queued", bank_q.size() != 0, 1);
            if (bank_q.size() != 0) rd_val = bank_q.pop_front();
            rd_pend = 1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (reg_write_strobe) begin
            chk("wr_strobe_expected", wq.size() != 0, 1);
            if (wq.size() != 0) begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_addr", reg_address, w.addr);
                chk("wr_data", reg_wdata, w.data);
            end
        end
        if (reg_read_strobe) begin
            rs_cyc = cyc;
            chk("rd_strobe_expected", rq.size() != 0, 1);
            if (rq.size() != 0) chk("rd_addr", reg_address, rq.pop_front());
        end
        if (out_valid && !ov_prev) chk("rd_to_valid_latency", cyc - rs_cyc, 2);
        ov_prev = out_valid;
        if (out_valid && out_ack && !reset) begin
            chk("out_byte_expected", oq.size() != 0, 1);
            if (oq.size() != 0) chk("out_byte", out_byte, oq.pop_front());
        end
        if (frame_error) begin
            chk("fe_expected", fe_expect > 0, 1);
            if (fe_expect > 0) fe_expect--;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; RW = 1'b0;
        in_byte = '0; in_valid = 1'b0; out_ack = 1'b0;
        repeat (3) cycle();
        check_zero("reset");
        reset = 1'b0;

        repeat (4) begin
            in_valid = 1'b1;
            in_byte  = 8'($urandom);
            out_ack  = 1'($urandom);
            cycle();
            chk("noise_idle_busy", busy, 0);
        end
        in_valid = 1'b0;
        out_ack  = 1'b0;

        write_frame(8'h05, 32'h44332211, NB, 1'b1);
        read_frame(8'h09, 32'hA1B2C3D4, NB);
        write_frame(8'h05, 32'h00000011, 1, 1'b0);
        read_frame(8'h21, $urandom, NB);
        read_frame(8'h33, $urandom, 2);
        reset_mid();

        for (int n = 0; n < 40; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r <= 3)      write_frame(8'($urandom), $urandom, NB, 1'($urandom));
            else if (r <= 6) read_frame(8'($urandom), $urandom, NB);
            else if (r == 7) write_frame(8'($urandom), $urandom, $urandom_range(0, NB - 1), 1'($urandom));
            else if (r == 8) read_frame(8'($urandom), $urandom, $urandom_range(0, NB - 1));
            else if (mid_frame) reset_mid();
            else write_frame(8'($urandom), $urandom, NB, 1'b0);
        end
        if (mid_frame) reset_mid();
        repeat (3) cycle();

        chk("end_wq_empty", wq.size(), 0);
        chk("end_rq_empty", rq.size(), 0);
        chk("end_oq_empty", oq.size(), 0);
        chk("end_bank_empty", bank_q.size(), 0);
        chk("end_fe_pending", fe_expect, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/up_byte_assembler.md
UP_BYTE_ASSEMBLER -- requirements
Module: uP_byte_assembler

Interface
REQ-001 Parameter DATA_BYTES, default 4: number of data bytes per register transfer; register width is 8*DATA_BYTES.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse marking start of a new frame from the uP interface state machine.
REQ-005 RW  input  1  frame direction, sampled with start: 0 = write, 1 = read.
REQ-006 in_byte  input  8  byte received from the microcontroller.
REQ-007 in_valid  input  1  one-cycle strobe; in_byte is valid.
REQ-008 reg_rdata  input  32  read data returned by the register bank, valid one cycle after reg_read_strobe.
REQ-009 out_ack  input  1  uP side has consumed out_byte.
REQ-010 reg_address  output  8  target register address.
REQ-011 reg_wdata  output  32  assembled write data.
REQ-012 reg_write_strobe  output  1  one-cycle write command.
REQ-013 reg_read_strobe  output  1  one-cycle read command.
REQ-014 out_byte  output  8  byte to send to the microcontroller.
REQ-015 out_valid  output  1  out_byte valid; held until out_ack.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 frame_error  output  1  one-cycle pulse on aborted frame.

Function
REQ-018 States SHALL be IDLE, GET_ADDR, GET_DATA, DO_WRITE, DO_READ, CAPTURE, SEND.
REQ-019 IDLE: start=1 -> GET_ADDR, latch RW; in_valid without start SHALL be ignored.
REQ-020 GET_ADDR: in_valid -> reg_address <= in_byte; next state GET_DATA if RW=0, DO_READ if RW=1.
REQ-021 GET_DATA: each in_valid SHALL load in_byte into byte lane byte_count of reg_wdata (lane 0 = bits 7:0, little-endian) and increment byte_count.
REQ-022 GET_DATA: in_valid carrying byte DATA_BYTES-1 -> DO_WRITE.
REQ-023 DO_WRITE: reg_write_strobe=1 for exactly one cycle, then IDLE; reg_wdata and reg_address SHALL remain stable through that cycle.
REQ-024 DO_READ: reg_read_strobe=1 for exactly one cycle -> CAPTURE.
REQ-025 CAPTURE: shift register <= reg_rdata; byte_count <= 0 -> SEND.
REQ-026 SEND: out_valid=1, out_byte = shift register bits 7:0 (LSB first).
REQ-027 SEND: out_ack while out_valid -> shift right 8, increment byte_count; the ack of byte DATA_BYTES-1 -> IDLE with out_valid=0 the following cycle.
REQ-028 out_ack while out_valid=0 SHALL be ignored.
REQ-029 byte_count SHALL be 3 bits, cleared on entry to GET_DATA and CAPTURE; it SHALL never wrap within a frame.
REQ-030 start in any state other than IDLE SHALL abort the frame: frame_error=1 for one cycle, out_valid=0, RW re-latched, next state GET_ADDR; no register strobe issued.
REQ-031 start and in_valid in the same cycle: start wins, the byte is discarded.
REQ-032 Latency: write strobe one cycle after final data byte; out_valid two cycles after the read strobe cycle.

Reset
REQ-033 reset=1 SHALL force IDLE from any state, including mid-frame, with no strobe issued.
REQ-034 Reset values: reg_address=0, reg_wdata=0, shift register=0, byte_count=0, out_byte=0, all strobes, out_valid, busy and frame_error 0.
REQ-035 reset SHALL take priority over start, in_valid and out_ack in the same cycle.

Verification
REQ-036 Write: start(RW=0), bytes 0x05,0x11,0x22,0x33,0x44 -> one reg_write_strobe, reg_address=0x05, reg_wdata=0x44332211.
REQ-037 Read: start(RW=1), byte 0x09, reg_rdata=0xA1B2C3D4 -> reg_read_strobe once, out_byte 0xD4,0xC3,0xB2,0xA1 each held until out_ack, then busy=0.
REQ-038 Abort: start(RW=0), 0x05, 0x11, then start(RW=1) -> frame_error pulse, no write strobe, new read frame completes normally.
REQ-039 Reset mid-read: reset during SEND after 2 acks -> next cycle out_valid=0, busy=0, all outputs at reset values.
REQ-040 Noise: in_valid in IDLE and out_ack with out_valid=0 -> no state change, no strobe; start+in_valid together -> byte discarded, state GET_ADDR.
